// File: rtl/is_pkg_uart_controller.sv
// Shared definitions for the UART controller: receive FSM states and default
// frame geometry used by the serial front-end.
package is_pkg_uart_controller;

   localparam int UART_DATA_W = 8;
   localparam int UART_RATIO  = 8;

   typedef enum logic [2:0] {
      IDLE,
      RSTRB,
      RDT,
      RPARB,
      RSTB1,
      RSTB2,
      WEND
   } state_r;

endpackage

// File: rtl/is_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module is_sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receive front-end: oversampled deframing of start/data/parity/stop bits,
// with a one-entry holding register on a valid/ready interface.
module uart_rx
   import is_pkg_uart_controller::*;
#(
   parameter int DATA_W     = UART_DATA_W,
   parameter int RATIO      = UART_RATIO,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              rx_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              par_err_o,
   output logic              frm_err_o,
   output logic              ovr_err_o,
   output logic              busy_o
);

   localparam int CNT_W = $clog2(RATIO);
   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(RATIO / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(RATIO - 1);
   localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DATA_W - 1);

   logic              rx;
   state_r            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bitcnt;
   logic [DATA_W-1:0] shreg;
   logic              armed;
   logic              perr;
   logic              ferr;
   logic              at_end;
   logic              load;

   function automatic logic parity_err(input logic [DATA_W-1:0] d, input logic p);
      return (^d ^ p ^ PARITY_ODD) != 1'b0;
   endfunction

   is_sync_2ff #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (rx_i),
      .q  (rx)
   );

   assign at_end = tick_i && (cnt == CNT_END);

   // Frame FSM: every transition is tick-qualified except the single WEND cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         armed  <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (tick_i) begin
                  cnt <= '0;
                  if (rx) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     armed  <= 1'b0;
                     perr   <= 1'b0;
                     ferr   <= 1'b0;
                     bitcnt <= '0;
                     state  <= RSTRB;
                  end
               end
            end
            RSTRB: begin
               if (tick_i) begin
                  if (cnt == CNT_MID) begin
                     cnt   <= '0;
                     state <= rx ? IDLE : RDT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RDT: begin
               if (at_end) begin
                  cnt    <= '0;
                  shreg  <= {rx, shreg[DATA_W-1:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == BIT_END) begin
                     state <= PARITY_EN ? RPARB : RSTB1;
                  end
               end else if (tick_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RPARB: begin
               if (at_end) begin
                  cnt   <= '0;
                  perr  <= parity_err(shreg, rx);
                  state <= RSTB1;
               end else if (tick_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RSTB1: begin
               if (at_end) begin
                  cnt <= '0;
                  if (!rx) begin
                     ferr <= 1'b1;
                  end
                  state <= (STOP_BITS == 1) ? WEND : RSTB2;
               end else if (tick_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RSTB2: begin
               if (at_end) begin
                  cnt <= '0;
                  if (!rx) begin
                     ferr <= 1'b1;
                  end
                  state <= WEND;
               end else if (tick_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            WEND: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // A completed byte loads only if the slot is free or draining this cycle.
   assign load      = (state == WEND) && (!valid_o || ready_i);
   assign ovr_err_o = (state == WEND) && valid_o && !ready_i;
   assign busy_o    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_o    <= '0;
         valid_o   <= 1'b0;
         par_err_o <= 1'b0;
         frm_err_o <= 1'b0;
      end else if (load) begin
         data_o    <= shreg;
         valid_o   <= 1'b1;
         par_err_o <= perr;
         frm_err_o <= ferr;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

   localparam int DATA_W     = 8;
   localparam int RATIO      = 8;
   localparam bit PARITY_ODD = 1'b0;
   localparam int TPER       = 4;
   localparam int BIT        = RATIO * TPER;

   logic              clk;
   logic              rst;
   logic              tick_i;
   logic              rx_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;
   logic              par_err_o;
   logic              frm_err_o;
   logic              ovr_err_o;
   logic              busy_o;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   xfer_cnt = 0;
   int   exp_xfer = 0;
   int   ovr_cnt = 0;
   int   vhi_cnt = 0;
   int   ready_mode = 1;
   logic [1:0] tdiv = '0;

   uart_rx #(
      .DATA_W    (DATA_W),
      .RATIO     (RATIO),
      .PARITY_EN (1'b1),
      .PARITY_ODD(PARITY_ODD),
      .STOP_BITS (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick_i),
      .rx_i     (rx_i),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .par_err_o(par_err_o),
      .frm_err_o(frm_err_o),
      .ovr_err_o(ovr_err_o),
      .busy_o   (busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tdiv   = tdiv + 2'd1;
         tick_i = (tdiv == 2'd0);
      end
   end

   initial begin
      ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       ready_i = 1'b0;
            1:       ready_i = 1'b1;
            default: ready_i = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ovr_err_o) ovr_cnt++;
      if (valid_o) vhi_cnt++;
      if (!rst && valid_o && ready_i) begin
         xfer_cnt++;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("data", {24'd0, data_o}, {24'd0, e.d});
            chk("par_err", {31'd0, par_err_o}, {31'd0, e.pe});
            chk("frm_err", {31'd0, frm_err_o}, {31'd0, e.fe});
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (($countones(d) % 2) != 0) ^ PARITY_ODD;
   endfunction

   // Reference model: a frame is expected with its byte, a parity error when the
   // ones-count of data plus parity bit disagrees with the chosen parity, and a
   // framing error when any stop bit was sent low.
   task automatic expect_frame(input logic [7:0] d, input logic pbit, input logic s1,
                               input logic s2);
      exp_t x;
      x.d  = d;
      x.pe = (($countones({d, pbit}) % 2) != int'(PARITY_ODD));
      x.fe = !(s1 && s2);
      q.push_back(x);
      exp_xfer++;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                             input logic s2, input bit do_exp);
      if (do_exp) expect_frame(d, pbit, s1, s2);
      rx_i = 1'b0;
      clks(BIT);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         clks(BIT);
      end
      rx_i = pbit;
      clks(BIT);
      rx_i = s1;
      clks(BIT);
      rx_i = s2;
      clks(BIT);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
      chk(tag, q.size(), 0);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, x0, o0;
      bit aligned;
      logic [7:0] d;
      logic pb, s1, s2;

      rst = 1'b1;
      rx_i = 1'b1;
      ready_mode = 1;
      clks(5);
      chk("rst_data", {24'd0, data_o}, 32'd0);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_perr", {31'd0, par_err_o}, 32'd0);
      chk("rst_ferr", {31'd0, frm_err_o}, 32'd0);
      chk("rst_ovr", {31'd0, ovr_err_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      rst = 1'b0;
      clks(2 * BIT);

      // Clean byte
      v0 = vhi_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
      rx_i = 1'b1;
      drain("clean_drain");
      clks(BIT);
      chk("clean_vld_width", vhi_cnt - v0, 1);

      // Parity error
      send_frame(8'h31, 1'b0, 1'b1, 1'b1, 1'b1);
      rx_i = 1'b1;
      drain("parity_drain");
      clks(BIT);

      // Start glitch, then a good frame
      x0 = xfer_cnt;
      rx_i = 1'b0;
      clks(2 * TPER);
      chk("glitch_busy_hi", {31'd0, busy_o}, 32'd1);
      rx_i = 1'b1;
      clks(24);
      chk("glitch_busy_lo", {31'd0, busy_o}, 32'd0);
      chk("glitch_no_byte", xfer_cnt - x0, 0);
      clks(BIT);
      send_frame(8'h0D, 1'b1, 1'b1, 1'b1, 1'b1);
      rx_i = 1'b1;
      drain("glitch_drain");
      clks(BIT);

      // Framing error followed by a long break
      send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("break_drain");
      x0 = xfer_cnt;
      clks(3 * 12 * BIT);
      chk("break_quiet", xfer_cnt - x0, 0);
      chk("break_busy", {31'd0, busy_o}, 32'd0);
      rx_i = 1'b1;
      clks(2 * BIT);

      // Overrun
      ready_mode = 0;
      clks(2);
      send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
      rx_i = 1'b1;
      clks(BIT);
      o0 = ovr_cnt;
      send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
      rx_i = 1'b1;
      clks(BIT);
      chk("ovr_pulses", ovr_cnt - o0, 1);
      chk("ovr_hold_data", {24'd0, data_o}, 32'h11);
      chk("ovr_hold_valid", {31'd0, valid_o}, 32'd1);
      expect_frame(8'h11, 1'b0, 1'b1, 1'b1);
      ready_mode = 1;
      drain("ovr_drain");
      chk("ovr_no_more", ovr_cnt - o0, 1);

      // Reset in the middle of a frame, with a byte parked in the holding register
      ready_mode = 0;
      clks(2);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
      rx_i = 1'b1;
      clks(BIT);
      chk("park_valid", {31'd0, valid_o}, 32'd1);
      chk("park_data", {24'd0, data_o}, 32'h3C);
      x0 = xfer_cnt;
      rx_i = 1'b0;
      clks(BIT);
      rx_i = 1'b1;
      clks(3 * BIT + BIT / 2);
      chk("mid_busy", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mrst_data", {24'd0, data_o}, 32'd0);
      chk("mrst_valid", {31'd0, valid_o}, 32'd0);
      chk("mrst_perr", {31'd0, par_err_o}, 32'd0);
      chk("mrst_ferr", {31'd0, frm_err_o}, 32'd0);
      chk("mrst_ovr", {31'd0, ovr_err_o}, 32'd0);
      chk("mrst_busy", {31'd0, busy_o}, 32'd0);
      clks(BIT / 2 + 4 * BIT);
      rx_i = 1'b0;
      clks(BIT / 4);
      aligned = 1'b0;
      for (int i = 0; i < 8 && !aligned; i++) begin
         @(posedge clk);
         if (tick_i) aligned = 1'b1;
      end
      #1;
      rst = 1'b0;
      ready_mode = 1;
      clks(BIT / 2);
      chk("remnant_low_busy", {31'd0, busy_o}, 32'd0);
      rx_i = 1'b1;
      clks(4 * BIT);
      chk("remnant_no_byte", xfer_cnt - x0, 0);
      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
      rx_i = 1'b1;
      drain("post_rst_drain");
      clks(BIT);

      // Randomized frames with random back-pressure
      ready_mode = 2;
      for (int n = 0; n < 20; n++) begin
         d  = 8'($urandom);
         pb = good_par(d) ^ ($urandom_range(0, 4) == 0);
         s1 = ($urandom_range(0, 9) != 0);
         s2 = ($urandom_range(0, 9) != 0);
         send_frame(d, pb, s1, s2, 1'b1);
         rx_i = 1'b1;
         clks(BIT * $urandom_range(1, 3));
      end
      drain("random_drain");
      ready_mode = 1;
      clks(BIT);

      chk("xfer_total", xfer_cnt, exp_xfer);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front-end of the UART controller. Samples the asynchronous `rx` line at `RATIO`× the baud rate, deframes start / `DATA_W` data / optional parity / 1–2 stop bits, and presents each byte with error flags on a valid/ready interface. The frame FSM downstream (RDT/RCR/RLF parsing) consumes this interface.

## Interface
- `DATA_W`, default 8: data bits per frame, sent LSB first.
- `RATIO`, default 8: oversampling ticks per bit; must be even and ≥ 4.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, default 2: number of stop bits, 1 or 2.
- `clk` input 1: system clock, the only clock.
- `rst` input 1: reset, asynchronous and active-high.
- `tick_i` input 1: oversample enable, one-`clk` pulse at `RATIO`× baud, from the baud generator.
- `rx_i` input 1: asynchronous serial line, idles high.
- `data_o` output `DATA_W`: received byte.
- `valid_o` output 1: `data_o` and the error flags are valid.
- `ready_i` input 1: consumer accepts; a transfer happens on a cycle with `valid_o & ready_i`.
- `par_err_o` output 1: parity mismatch for the byte in `data_o`; qualified by `valid_o`.
- `frm_err_o` output 1: a stop bit sampled 0 for the byte in `data_o`; qualified by `valid_o`.
- `ovr_err_o` output 1: one-`clk` pulse when a completed byte is dropped.
- `busy_o` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input sync:** `rx_i` passes through a 2-FF synchronizer that resets to 1. All references to "rx" below mean the synchronized value.
- **Tick counter:** `cnt` has width $clog2(RATIO) and advances only on `tick_i`. All FSM transitions except the WEND exit happen on `tick_i`.
- **IDLE:** if `armed` and rx = 0 on a tick, go to RSTRB with `cnt` = 0. `armed` is set by any tick with rx = 1 and cleared on entry to RSTRB.
- **RSTRB:** on the tick where `cnt` = RATIO/2−1 (mid-bit), check rx.
  - rx = 0: go to RDT with `cnt` = 0.
  - rx = 1: glitch; return to IDLE and emit no output.
- **RDT:** on each tick where `cnt` = RATIO−1, shift rx into the MSB of the shift register (LSB-first reception) and wrap `cnt`. After `DATA_W` samples, go to RPARB if `PARITY_EN`, otherwise RSTB1.
- **RPARB:** sample at `cnt` = RATIO−1. Set `perr` = (^data ^ rx ^ PARITY_ODD) ≠ 0. Go to RSTB1.
- **RSTB1 / RSTB2:** sample at `cnt` = RATIO−1. A 0 sets `ferr`. After the last stop bit (RSTB1 if `STOP_BITS` = 1, else RSTB2), go to WEND.
  - The FSM never aborts mid-frame; a framing error still delivers the byte.
- **WEND:** lasts one `clk` without waiting for a tick, then goes to IDLE. In WEND:
  - If the holding register is empty or is being transferred this cycle, load `data_o`, `par_err_o` and `frm_err_o`, and set `valid_o`.
  - Otherwise keep the old byte and pulse `ovr_err_o`.
- **Holding register:** `valid_o` clears after a transfer unless a load happens on the same cycle.
- **Reset (also mid-frame):** state = IDLE, `cnt` = 0, shift register = 0, `armed` = 0, synchronizer = 1.
  - All outputs are 0, including `data_o`, `valid_o`, every error flag and `busy_o`.
  - A line held low after reset is never taken as a start bit until a high tick is seen.

## Timing
- The synchronizer adds 2 `clk` of latency ahead of every sample.
- Start bit is verified RATIO/2 ticks after the detection tick. Each following bit is sampled RATIO ticks after the previous sample, i.e. at mid-bit.
- Let edge E be the `clk` edge carrying the final stop-bit tick. At E the state becomes WEND; at E+1 `valid_o` goes high. Latency is therefore 1 `clk` after the last sample.
- `valid_o` holds until `ready_i`. A back-to-back frame can never load earlier than 1 + 2·RATIO ticks after the previous WEND.
- `ovr_err_o` is high for exactly the WEND cycle of the dropped byte.

## Structure
- The state enum `state_r` (IDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2, WEND) lives in package `is_pkg_uart_controller`.
- The defaults `DATA_W` and `RATIO` are taken from the same package. Parity and stop-bit settings stay local parameters.
- One sub-module: `is_sync_2ff` (2-FF synchronizer, 1-bit, reset value parameter = 1). Everything else stays in a single always_ff FSM plus a holding-register process.

## Test plan
- **Clean byte:** `tick_i` 1-in-4 clk, send 0xA5 with even parity bit 0 and 2 stop bits, `ready_i` = 1. Expect `data_o` = 0xA5 with `valid_o` for 1 clk, `par_err_o` = 0, `frm_err_o` = 0.
- **Parity error:** send 0x31 with parity bit 0 (correct even parity is 1). Expect `data_o` = 0x31 with `par_err_o` = 1.
- **Start glitch:** rx low for 2 ticks, then high. Expect no `valid_o`, `busy_o` back to 0 after RATIO/2 ticks; a following 0x0D frame is received correctly.
- **Framing error / break:** send 0x0A with stop1 = 0. Expect 0x0A with `frm_err_o` = 1. Then hold rx low for 3 frame times: expect no further bytes until rx returns high and a new start arrives.
- **Overrun:** `ready_i` = 0, send 0x11 then 0x22. Expect `data_o` to stay 0x11, `ovr_err_o` to pulse once at the second WEND, and a later `ready_i` to transfer 0x11.
- **Reset mid-frame:** assert `rst` during RDT of 0xFF. Expect outputs 0 immediately. After release, a fresh 0x55 is received correctly and the remnant of the 0xFF frame produces nothing.
